// File: rtl/mmio_timer_io.sv
// Memory-mapped I/O block: LED register, synchronized switch inputs and an optional
// prescaled countdown timer (compiled in when MMIO_TIMER_EN is defined).
module mmio_timer_io #(
  parameter int PRESCALE = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  mem_cmd,
  input  logic [8:0]  mem_addr,
  input  logic [15:0] din,
  output logic [15:0] mem_data,
  input  logic [7:0]  SW,
  output logic [7:0]  led,
  output logic        tmr_flag
);

  localparam logic [1:0] CMD_READ  = 2'b10;
  localparam logic [1:0] CMD_WRITE = 2'b01;

  logic        rd, wr, hit;
  logic        sel_led, sel_sw, sel_tcnt, sel_tctl;
  logic [7:0]  sw_meta, sw_sync;
  logic [15:0] rdata_q, rdata_sel;

  assign rd      = (mem_cmd == CMD_READ);
  assign wr      = (mem_cmd == CMD_WRITE);
  assign sel_led = (mem_addr == 9'h100);
  assign sel_sw  = (mem_addr == 9'h140);
  assign hit     = sel_led | sel_sw | sel_tcnt | sel_tctl;

  // Read data lags the address by one edge; the bus is only driven while the read is held.
  assign mem_data = (rd && hit) ? rdata_q : 16'hzzzz;

`ifdef MMIO_TIMER_EN
  localparam logic [15:0] PRE_MAX = 16'(PRESCALE - 1);

  logic [15:0] tload, tcount, presc;
  logic        en, auto_rl, flag;
  logic        load_wr, ctrl_wr, tick, expire;

  assign sel_tcnt = (mem_addr == 9'h180);
  assign sel_tctl = (mem_addr == 9'h181);
  assign load_wr  = wr && sel_tcnt;
  assign ctrl_wr  = wr && sel_tctl;
  assign tick     = en && (tcount != 16'd0) && (presc == PRE_MAX);
  // A reload write on the tick edge swallows the tick, so it cannot expire either.
  assign expire   = tick && !load_wr && (tcount == 16'd1);
  assign tmr_flag = flag;

  always_ff @(posedge clk) begin
    if (reset) begin
      tload   <= '0;
      tcount  <= '0;
      presc   <= '0;
      en      <= 1'b0;
      auto_rl <= 1'b0;
      flag    <= 1'b0;
    end else begin
      if (load_wr) begin
        tload  <= din;
        tcount <= din;
        presc  <= '0;
      end else begin
        if (en && tcount != 16'd0) presc <= tick ? 16'd0 : presc + 16'd1;
        else                       presc <= '0;
        if (tick) tcount <= (tcount > 16'd1) ? tcount - 16'd1 : (auto_rl ? tload : 16'd0);
      end
      if (ctrl_wr) begin
        en      <= din[0];
        auto_rl <= din[1];
      end
      if (expire)                flag <= 1'b1;
      else if (ctrl_wr && din[15]) flag <= 1'b0;
    end
  end
`else
  logic unused_din;
  assign unused_din = ^din[15:8];
  assign sel_tcnt   = 1'b0;
  assign sel_tctl   = 1'b0;
  assign tmr_flag   = 1'b0;
`endif

  always_comb begin
    rdata_sel = '0;
    if (sel_led) rdata_sel = {8'h00, led};
    if (sel_sw)  rdata_sel = {8'h00, sw_sync};
`ifdef MMIO_TIMER_EN
    if (sel_tcnt) rdata_sel = tcount;
    if (sel_tctl) rdata_sel = {flag, 13'd0, auto_rl, en};
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sw_meta <= '0;
      sw_sync <= '0;
      led     <= '0;
      rdata_q <= '0;
    end else begin
      sw_meta <= SW;
      sw_sync <= sw_meta;
      if (wr && sel_led) led <= din[7:0];
      rdata_q <= rdata_sel;
    end
  end

endmodule

// File: tb/tb_mmio_timer_io.sv
// Directed bench for mmio_timer_io (PRESCALE=4): bus vector table plus timer corner sequences.
module tb_mmio_timer_io;

  localparam logic [1:0] NOP = 2'b00, RD = 2'b10, WR = 2'b01;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [15:0] din;
  tri1  [15:0] mem_data;
  logic [7:0]  SW;
  logic [7:0]  led;
  logic        tmr_flag;

  int checks = 0;
  int errors = 0;

  mmio_timer_io #(.PRESCALE(4)) dut (
    .clk(clk), .reset(reset), .mem_cmd(mem_cmd), .mem_addr(mem_addr), .din(din),
    .mem_data(mem_data), .SW(SW), .led(led), .tmr_flag(tmr_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  cmd;
    logic [8:0]  addr;
    logic [15:0] din;
    logic [7:0]  sw;
    logic [7:0]  led;
    logic        z;
    logic [15:0] data;
  } vec_t;

  vec_t tv[17];

  task automatic cyc(input logic [1:0] c, input logic [8:0] a, input logic [15:0] d);
    mem_cmd = c; mem_addr = a; din = d;
    @(posedge clk); #1;
  endtask

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, got, exp);
    end
  endtask

  // Undriven bus resolves to all ones on the pulled-up net.
  task automatic chk_z(input string nm);
    checks++;
    if (!(mem_data === 16'hffff || mem_data === 16'hzzzz)) begin
      errors++;
      $display("FAIL %s got %h expected zzzz", nm, mem_data);
    end
  endtask

  initial begin
    tv[0]  = '{WR,  9'h100, 16'h00A5, 8'h00, 8'hA5, 1'b1, 16'h0000};
    tv[1]  = '{RD,  9'h100, 16'h0000, 8'h00, 8'hA5, 1'b0, 16'h00A5};
    tv[2]  = '{RD,  9'h0FF, 16'h0000, 8'h00, 8'hA5, 1'b1, 16'h0000};
    tv[3]  = '{RD,  9'h140, 16'h0000, 8'h3C, 8'hA5, 1'b0, 16'h0000};
    tv[4]  = '{RD,  9'h140, 16'h0000, 8'h3C, 8'hA5, 1'b0, 16'h0000};
    tv[5]  = '{RD,  9'h140, 16'h0000, 8'h3C, 8'hA5, 1'b0, 16'h003C};
    tv[6]  = '{RD,  9'h1FF, 16'h0000, 8'h3C, 8'hA5, 1'b1, 16'h0000};
    tv[7]  = '{WR,  9'h140, 16'hFFFF, 8'h3C, 8'hA5, 1'b1, 16'h0000};
    tv[8]  = '{RD,  9'h140, 16'h0000, 8'h3C, 8'hA5, 1'b0, 16'h003C};
    tv[9]  = '{WR,  9'h101, 16'h0011, 8'h3C, 8'hA5, 1'b1, 16'h0000};
    tv[10] = '{WR,  9'h000, 16'h005A, 8'h3C, 8'hA5, 1'b1, 16'h0000};
    tv[11] = '{RD,  9'h100, 16'h0000, 8'h3C, 8'hA5, 1'b0, 16'h00A5};
    tv[12] = '{WR,  9'h100, 16'h1234, 8'h3C, 8'h34, 1'b1, 16'h0000};
    tv[13] = '{RD,  9'h100, 16'h0000, 8'h3C, 8'h34, 1'b0, 16'h0034};
    tv[14] = '{NOP, 9'h100, 16'h0000, 8'h3C, 8'h34, 1'b1, 16'h0000};
`ifdef MMIO_TIMER_EN
    tv[15] = '{RD,  9'h181, 16'h0000, 8'h3C, 8'h34, 1'b0, 16'h0000};
    tv[16] = '{RD,  9'h180, 16'h0000, 8'h3C, 8'h34, 1'b0, 16'h0000};
`else
    tv[15] = '{RD,  9'h181, 16'h0000, 8'h3C, 8'h34, 1'b1, 16'h0000};
    tv[16] = '{RD,  9'h180, 16'h0000, 8'h3C, 8'h34, 1'b1, 16'h0000};
`endif

    reset = 1'b1; mem_cmd = NOP; mem_addr = '0; din = '0; SW = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_led", {8'h00, led}, 16'h0000);
    chk("reset_flag", {15'd0, tmr_flag}, 16'h0000);
    chk_z("reset_bus_z");
    reset = 1'b0;

    for (int i = 0; i < 17; i++) begin
      SW = tv[i].sw;
      cyc(tv[i].cmd, tv[i].addr, tv[i].din);
      chk($sformatf("vec%0d_led", i), {8'h00, led}, {8'h00, tv[i].led});
      if (tv[i].z) chk_z($sformatf("vec%0d_z", i));
      else         chk($sformatf("vec%0d_data", i), mem_data, tv[i].data);
    end

`ifdef MMIO_TIMER_EN
    // Auto-reload, then a flag clear landing on the expiry edge.
    cyc(WR, 9'h180, 16'h0002);
    cyc(WR, 9'h181, 16'h0003);
    mem_cmd = RD; mem_addr = 9'h180;
    for (int k = 1; k <= 15; k++) begin
      @(posedge clk); #1;
      if (k == 7)  chk("auto_flag_pre", {15'd0, tmr_flag}, 16'h0000);
      if (k == 8)  chk("auto_cnt_e8", mem_data, 16'h0001);
      if (k == 8)  chk("auto_flag_set", {15'd0, tmr_flag}, 16'h0001);
      if (k == 9)  chk("auto_reload", mem_data, 16'h0002);
      if (k == 13) chk("auto_cnt_e13", mem_data, 16'h0001);
    end
    cyc(WR, 9'h181, 16'h8003);
    chk("clear_vs_expire", {15'd0, tmr_flag}, 16'h0001);
    cyc(RD, 9'h180, 16'h0000);
    chk("auto_reload2", mem_data, 16'h0002);
    cyc(WR, 9'h181, 16'h8003);
    chk("flag_clear", {15'd0, tmr_flag}, 16'h0000);
    cyc(WR, 9'h181, 16'h0000);

    // One-shot countdown 3,2,1,0 at four-cycle intervals.
    cyc(WR, 9'h180, 16'h0003);
    cyc(WR, 9'h181, 16'h0001);
    mem_cmd = RD; mem_addr = 9'h180;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (k == 1)  chk("oneshot_c3", mem_data, 16'h0003);
      if (k == 4)  chk("oneshot_hold3", mem_data, 16'h0003);
      if (k == 5)  chk("oneshot_c2", mem_data, 16'h0002);
      if (k == 9)  chk("oneshot_c1", mem_data, 16'h0001);
      if (k == 11) chk("oneshot_flag_pre", {15'd0, tmr_flag}, 16'h0000);
      if (k == 12) chk("oneshot_flag", {15'd0, tmr_flag}, 16'h0001);
      if (k == 13) chk("oneshot_c0", mem_data, 16'h0000);
      if (k == 20) chk("oneshot_stay0", mem_data, 16'h0000);
    end
    cyc(RD, 9'h181, 16'h0000);
    chk("tctrl_read", mem_data, 16'h8001);

    // Reload write on the tick edge wins over the decrement.
    cyc(WR, 9'h180, 16'h0009);
    repeat (3) cyc(NOP, 9'h000, 16'h0000);
    cyc(WR, 9'h180, 16'h0007);
    mem_cmd = RD; mem_addr = 9'h180;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      if (k == 1) chk("load_vs_tick", mem_data, 16'h0007);
      if (k == 4) chk("load_tick_hold", mem_data, 16'h0007);
      if (k == 5) chk("load_tick_dec", mem_data, 16'h0006);
    end

    // Reset mid-countdown beats a same-edge LED write.
    cyc(WR, 9'h180, 16'h0005);
    repeat (2) cyc(NOP, 9'h000, 16'h0000);
    reset = 1'b1;
    cyc(WR, 9'h100, 16'h00FF);
    chk("rst_led", {8'h00, led}, 16'h0000);
    chk("rst_flag", {15'd0, tmr_flag}, 16'h0000);
    reset = 1'b0;
    cyc(RD, 9'h180, 16'h0000);
    chk("rst_tcount", mem_data, 16'h0000);
    cyc(RD, 9'h181, 16'h0000);
    chk("rst_tctrl", mem_data, 16'h0000);
    cyc(RD, 9'h100, 16'h0000);
    chk("rst_led_read", mem_data, 16'h0000);
`else
    cyc(WR, 9'h181, 16'h0003);
    cyc(WR, 9'h180, 16'h0001);
    cyc(RD, 9'h180, 16'h0000);
    chk_z("notimer_tcount_z");
    cyc(RD, 9'h181, 16'h0000);
    chk_z("notimer_tctrl_z");
    repeat (8) cyc(NOP, 9'h000, 16'h0000);
    chk("notimer_flag", {15'd0, tmr_flag}, 16'h0000);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmio_timer_io.md
MMIO_TIMER_IO -- requirements
Module: mmio_timer_io

Interface
REQ-001 SHALL have parameter: PRESCALE, 50000, clk cycles per timer tick (1 ms at 50 MHz); legal range 1..65535.
REQ-002 SHALL have port: clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: mem_cmd  input  2  bus command: 2'b00 NOP, 2'b10 READ, 2'b01 WRITE.
REQ-005 SHALL have port: mem_addr  input  9  bus address; bit 8 = 1 selects I/O space.
REQ-006 SHALL have port: din  input  16  CPU write data.
REQ-007 SHALL have port: mem_data  output  16  read data, tri-stated (all z) unless this block responds.
REQ-008 SHALL have port: SW  input  8  asynchronous board switches.
REQ-009 SHALL have port: led  output  8  LED register contents.
REQ-010 SHALL have port: tmr_flag  output  1  timer expired flag (sticky).

Function
REQ-011 SHALL decode addresses only when mem_addr[8]=1: 0x100 LED, 0x140 SW, 0x180 TLOAD/TCOUNT, 0x181 TCTRL; all other I/O addresses are unmapped.
REQ-012 SHALL update registers on WRITE at the clock edge where mem_cmd=01 and the address hits; writes to unmapped or read-only addresses are ignored.
REQ-013 SHALL register read data every clock (rdata_q <= selected register) and drive mem_data=rdata_q only while mem_cmd=10 and the current address hits, giving one-cycle read latency.
REQ-014 LED: 8-bit read/write; reads return {8'h00, led}.
REQ-015 SW: read-only; sampled through a two-flop synchronizer; reads return {8'h00, sw_sync}; a change on SW is visible no later than the third edge after it.
REQ-016 Writing 0x180 SHALL load both TLOAD and TCOUNT with din and clear the prescaler; reading 0x180 returns TCOUNT.
REQ-017 TCTRL: bit0 EN and bit1 AUTO are read/write; bit15 FLAG is read-only-set; a write with din[15]=1 clears FLAG; the other bits read 0.
REQ-018 Prescaler SHALL count 0..PRESCALE-1 while EN=1 and TCOUNT!=0, emitting a one-cycle tick at PRESCALE-1 and then wrapping to 0; it SHALL hold at 0 while EN=0.
REQ-019 On tick: if TCOUNT>1, TCOUNT decrements; if TCOUNT=1, FLAG sets and TCOUNT becomes TLOAD when AUTO=1, else 0.
REQ-020 TCOUNT=0 with EN=1 SHALL produce no ticks, no decrement and no flag.
REQ-021 A TLOAD write coinciding with a tick SHALL win: the new value is loaded and the tick is discarded.
REQ-022 A FLAG clear coinciding with an expiry SHALL leave FLAG set.
REQ-023 tmr_flag SHALL equal FLAG combinationally.

Reset
REQ-024 On reset, led, TLOAD, TCOUNT, prescaler, EN, AUTO, FLAG, rdata_q and the synchronizer SHALL clear to 0; mem_data SHALL be z.
REQ-025 Reset asserted mid-countdown SHALL take priority over any same-edge bus write or tick.

Configuration
REQ-026 With macro MMIO_TIMER_EN defined, the timer (0x180, 0x181, tmr_flag) SHALL be implemented as above.
REQ-027 Without MMIO_TIMER_EN, 0x180 and 0x181 SHALL be unmapped (reads z, writes ignored), tmr_flag SHALL be tied to 0, and no timer or prescaler state SHALL exist.

Verification (PRESCALE=4, MMIO_TIMER_EN defined)
REQ-028 SHALL cover: write 0x100=0x00A5 -> led=0xA5 next edge; READ 0x100 -> mem_data=0x00A5 one cycle later; READ 0x0FF -> mem_data=z.
REQ-029 SHALL cover: SW=0x3C -> READ 0x140 returns 0x003C by the third edge; READ 0x1FF -> z; write 0x140 -> no state change.
REQ-030 SHALL cover: load 0x0003 then TCTRL=0x0001 -> TCOUNT 3,2,1,0 at 4-cycle intervals; FLAG set when TCOUNT reaches 0; TCOUNT stays 0.
REQ-031 SHALL cover: load 0x0002 with TCTRL=0x0003 -> FLAG set, TCOUNT reloads to 2; write TCTRL=0x8003 on the expiry edge -> FLAG stays 1.
REQ-032 SHALL cover: reset asserted with TCOUNT=5 and EN=1 -> all registers 0, tmr_flag=0 and led=0 on the next edge.
REQ-033 SHALL cover: build without MMIO_TIMER_EN, READ 0x180 -> z; tmr_flag held at 0.
